wb_master_bridge: RTL and testbench

- Wishbone initiator connecting one CPU pipeline memory port (instruction fetch or load/store) to the shared Wishbone bus, facing the bus RAM responder and other responders.
- Converts a level-held CPU request into one single-beat classic Wishbone cycle and stalls the pipeline until acknowledge.
- Returns read data and holds it while the pipeline is stalled for other reasons.
- Supports flush abort and a bus timeout.

---
 rtl/wb_master_bridge.sv | 129 ++++++++++++
 tb/tb_wb_master_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_bridge.sv
// Single-beat classic Wishbone initiator for one CPU pipeline memory port.
// A level-held CPU request becomes one registered bus cycle. The pipeline is
// stalled until ack, flush or timeout. Read data is held while the stage is
// stalled by another source.
module wb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stall_req_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] wishbone_addr_o,
  output logic [DATA_W-1:0] wishbone_data_o,
  output logic              wishbone_we_o,
  output logic [SEL_W-1:0]  wishbone_sel_o,
  output logic              wishbone_stb_o,
  output logic              wishbone_cyc_o,
  input  logic [DATA_W-1:0] wishbone_data_i,
  input  logic              wishbone_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] rd_buf;
  logic              to_hit;
  logic              launch;
  logic              bus_drop;

  // Final no-ack BUSY cycle: counter has seen TIMEOUT-1 earlier cycles.
  assign to_hit = (cnt == 8'(TIMEOUT - 1));

  // Next state and the combinational pipeline-facing outputs.
  always_comb begin
    state_nxt   = state;
    stall_req_o = 1'b0;
    cpu_data_o  = '0;
    launch      = 1'b0;
    bus_drop    = 1'b0;
    case (state)
      IDLE: begin
        stall_req_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          launch    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Flush beats ack, ack beats timeout.
        if (flush_i) begin
          bus_drop  = 1'b1;
          state_nxt = IDLE;
        end else if (wishbone_ack_i) begin
          bus_drop   = 1'b1;
          cpu_data_o = wishbone_we_o ? '0 : wishbone_data_i;
          state_nxt  = stall_i ? WAIT_STALL : IDLE;
        end else if (to_hit) begin
          bus_drop  = 1'b1;
          state_nxt = stall_i ? WAIT_STALL : IDLE;
        end else begin
          stall_req_o = 1'b1;
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf;
        if (!stall_i || flush_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, bus registers, read buffer, timeout counter and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rd_buf          <= '0;
      bus_err_o       <= 1'b0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_we_o   <= 1'b0;
      wishbone_sel_o  <= '0;
      wishbone_stb_o  <= 1'b0;
      wishbone_cyc_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_err_o <= 1'b0;
      if (launch) begin
        wishbone_addr_o <= cpu_addr_i;
        wishbone_data_o <= cpu_we_i ? cpu_data_i : '0;
        wishbone_we_o   <= cpu_we_i;
        wishbone_sel_o  <= cpu_sel_i;
        wishbone_stb_o  <= 1'b1;
        wishbone_cyc_o  <= 1'b1;
        cnt             <= '0;
      end else if (bus_drop) begin
        // Leaving BUSY always idles the bus; the next launch can only come
        // from IDLE, which guarantees a low stb/cyc cycle between requests.
        wishbone_addr_o <= '0;
        wishbone_data_o <= '0;
        wishbone_we_o   <= 1'b0;
        wishbone_sel_o  <= '0;
        wishbone_stb_o  <= 1'b0;
        wishbone_cyc_o  <= 1'b0;
        if (!flush_i && wishbone_ack_i) begin
          rd_buf <= wishbone_we_o ? '0 : wishbone_data_i;
        end else begin
          rd_buf    <= '0;
          bus_err_o <= !flush_i;
        end
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: RAM responder with programmable ack latency,
// word-level reference memory, directed scenarios plus random accesses.
module tb_wb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce, cpu_we, stall, flush;
  logic [31:0] cpu_addr, cpu_wdat, cpu_rdat;
  logic [3:0]  cpu_sel;
  logic        stall_req, bus_err;
  logic [31:0] wb_addr, wb_dout, wb_din;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;

  always #5 clk = ~clk;

  wb_master_bridge #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_sel_i(cpu_sel), .cpu_data_i(cpu_wdat), .cpu_data_o(cpu_rdat),
    .stall_req_o(stall_req), .stall_i(stall), .flush_i(flush),
    .bus_err_o(bus_err),
    .wishbone_addr_o(wb_addr), .wishbone_data_o(wb_dout),
    .wishbone_we_o(wb_we), .wishbone_sel_o(wb_sel),
    .wishbone_stb_o(wb_stb), .wishbone_cyc_o(wb_cyc),
    .wishbone_data_i(wb_din), .wishbone_ack_i(wb_ack)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h01030507) ^ 32'hA5A50000);
  endfunction

  // Responder: acks lat_cfg cycles after stb is first seen.
  int          lat_cfg;
  bit          no_ack, force_ack;
  logic        ack_r;
  logic [31:0] rdat_r;
  int          bcnt;
  logic [31:0] bmem [16];
  assign wb_ack = ack_r | force_ack;
  assign wb_din = rdat_r;

  always @(posedge clk) begin
    if (rst) begin
      ack_r  <= 1'b0;
      rdat_r <= '0;
      bcnt   <= 0;
      for (int i = 0; i < 16; i++) bmem[i] <= init_word(i);
    end else begin
      ack_r <= 1'b0;
      if (wb_cyc && wb_stb && !ack_r && !no_ack) begin
        if (bcnt + 1 >= lat_cfg) begin
          ack_r <= 1'b1;
          bcnt  <= 0;
          if (wb_we) begin
            for (int b = 0; b < 4; b++)
              if (wb_sel[b]) bmem[wb_addr[5:2]][8*b +: 8] <= wb_dout[8*b +: 8];
          end else begin
            rdat_r <= bmem[wb_addr[5:2]];
          end
        end else begin
          bcnt <= bcnt + 1;
        end
      end else begin
        bcnt <= 0;
      end
    end
  end

  // Reference memory and check bookkeeping.
  logic [31:0] ref_mem [16];
  int passes = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One CPU access started from a negedge; returns at the negedge of the ack cycle.
  task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wd, input int lat,
                        output logic [31:0] rd, output int n);
    logic [31:0] mask, exp;
    int   cyc_n;
    bit   done, ok;
    lat_cfg = lat;
    cpu_ce = 1'b1; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wdat = wd;
    n = 0; cyc_n = 0; done = 0; ok = 1; rd = 'x;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (wb_cyc) begin
        cyc_n++;
        if (wb_addr !== addr || wb_we !== we || wb_sel !== sel || !wb_stb ||
            wb_dout !== (we ? wd : 32'h0)) ok = 0;
      end
      if (wb_ack) begin
        done = 1;
        rd   = cpu_rdat;
        if (stall_req !== 1'b0) ok = 0;
      end else if (wb_cyc && stall_req !== 1'b1) ok = 0;
    end
    cpu_ce = 1'b0;
    chk("acc_done", 32'(done), 32'd1);
    chk("acc_bus_stable", 32'(ok), 32'd1);
    chk("acc_cyc_len", 32'(cyc_n), 32'(lat + 1));
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = sel[b] ? 8'hFF : 8'h00;
    if (we) ref_mem[addr[5:2]] = (ref_mem[addr[5:2]] & ~mask) | (wd & mask);
    exp = we ? 32'h0 : ref_mem[addr[5:2]];
    chk(we ? "acc_wr_data_o" : "acc_rd_data", rd, exp);
  endtask

  initial begin
    logic [31:0] rd, v;
    int n, cyc_n, st_n, err_n;
    logic [31:0] ra;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; cpu_ce = 0; cpu_we = 0; cpu_addr = 0; cpu_sel = 0; cpu_wdat = 0;
    stall = 0; flush = 0; lat_cfg = 1; no_ack = 0; force_ack = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cyc_stb", {30'h0, wb_cyc, wb_stb}, 32'h0);
    chk("rst_we_sel", {27'h0, wb_we, wb_sel}, 32'h0);
    chk("rst_addr", wb_addr, 32'h0);
    chk("rst_wdata", wb_dout, 32'h0);
    chk("rst_cpu_data", cpu_rdat, 32'h0);
    chk("rst_err_stall", {30'h0, bus_err, stall_req}, 32'h0);

    // Read with 1-cycle responder.
    access(0, 32'h10, 4'hF, 32'h0, 1, rd, n);
    chk("rd1_value", rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd1_gap", {30'h0, wb_cyc, wb_stb}, 32'h0);

    // Byte write then full-word read back.
    access(1, 32'h4, 4'h2, 32'h0000AB00, 1, rd, n);
    @(negedge clk);
    access(0, 32'h4, 4'hF, 32'h0, 1, rd, n);
    chk("byte1_readback", {24'h0, rd[15:8]}, 32'hAB);
    @(negedge clk);

    // Back-to-back reads with ce held: second access needs an idle gap cycle.
    access(0, 32'h20, 4'hF, 32'h0, 2, rd, n);
    access(0, 32'h24, 4'hF, 32'h0, 1, rd, n);
    chk("b2b_gap_len", 32'(n), 32'd3);
    @(negedge clk);

    // Read while stalled: data held through WAIT_STALL.
    stall = 1'b1;
    access(0, 32'h10, 4'hF, 32'h0, 2, rd, n);
    v = ref_mem[4];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_hold_data", cpu_rdat, v);
      chk("stall_hold_bus", {30'h0, wb_cyc, stall_req}, 32'h0);
    end
    stall = 1'b0;
    #1 chk("stall_last_data", cpu_rdat, v);
    @(negedge clk);
    chk("stall_idle_data", cpu_rdat, 32'h0);

    // Flush in the second BUSY cycle, slow responder, then a stray ack.
    lat_cfg = 4; cpu_ce = 1; cpu_we = 0; cpu_addr = 32'h8; cpu_sel = 4'hF;
    @(negedge clk);
    chk("flush_busy_cyc", 32'(wb_cyc), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_stall_req", 32'(stall_req), 32'd0);
    @(negedge clk);
    chk("flush_bus_idle", {30'h0, wb_cyc, wb_stb}, 32'h0);
    chk("flush_no_err", 32'(bus_err), 32'd0);
    flush = 1'b0; cpu_ce = 1'b0; force_ack = 1'b1;
    #1 chk("late_ack_data", cpu_rdat, 32'h0);
    @(negedge clk);
    force_ack = 1'b0;
    chk("late_ack_ignored", {29'h0, wb_cyc, bus_err, stall_req}, 32'h0);

    // Timeout with a silent responder.
    no_ack = 1; cpu_ce = 1; cpu_we = 0; cpu_addr = 32'h0; cpu_sel = 4'hF;
    cyc_n = 0; st_n = 0; err_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wb_cyc) cyc_n++;
      if (wb_cyc && stall_req) st_n++;
      if (wb_cyc && !stall_req) begin
        chk("to_final_data", cpu_rdat, 32'h0);
        cpu_ce = 1'b0;
      end
      if (bus_err) err_n++;
    end
    no_ack = 0;
    chk("to_cyc_len", 32'(cyc_n), 32'd8);
    chk("to_stall_len", 32'(st_n), 32'd7);
    chk("to_err_pulses", 32'(err_n), 32'd1);

    // Random accesses against the reference memory.
    for (int k = 0; k < 24; k++) begin
      ra = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      access(1'($urandom_range(0, 1)), ra, 4'($urandom_range(1, 15)), $urandom,
             $urandom_range(1, 4), rd, n);
      @(negedge clk);
      chk("rnd_gap", 32'(wb_cyc), 32'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of BUSY.
    lat_cfg = 4; cpu_ce = 1; cpu_we = 1; cpu_addr = 32'h2C; cpu_sel = 4'hF; cpu_wdat = 32'h12345678;
    repeat (2) @(negedge clk);
    rst = 1'b1; cpu_ce = 1'b0;
    @(negedge clk);
    chk("rstb_ctrl", {25'h0, wb_cyc, wb_stb, wb_we, bus_err, stall_req, 2'b0}, 32'h0);
    chk("rstb_sel", {28'h0, wb_sel}, 32'h0);
    chk("rstb_addr", wb_addr, 32'h0);
    chk("rstb_wdata", wb_dout, 32'h0);
    chk("rstb_cpu_data", cpu_rdat, 32'h0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
